// File: rtl/stepper_sched_pkg.sv
// Shared types and constants for the stepper move scheduler.
package stepper_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    TRIG,
    RUN
  } sched_state_t;

  typedef struct packed {
    logic signed [7:0] dx;
    logic signed [7:0] dy;
    logic        [7:0] width;
  } move_cmd_t;

  localparam int unsigned TRIG_TIMEOUT_TICKS = 4;

endpackage

// File: rtl/move_cmd_fifo.sv
// First-word-fall-through command FIFO; count-based flags, power-of-two depth.
module move_cmd_fifo
  import stepper_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         cmd_t = move_cmd_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic empty,
  output logic full
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  cmd_t                mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_BITS + 1)'(DEPTH));
  // Full is judged on the pre-pop count, so a pop never frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stepper_move_sched.sv
// Queues relative moves and issues each to both stepper axes in lockstep.
// Optional STEPPER_SCHED_STATS_EN adds a wrapping move_count output.
module stepper_move_sched
  import stepper_sched_pkg::*;
#(
  parameter int unsigned PULSE_NUM_BITS   = 8,
  parameter int unsigned PULSE_WIDTH_BITS = 8,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [PULSE_NUM_BITS-1:0]   cmd_dx,
  input  logic [PULSE_NUM_BITS-1:0]   cmd_dy,
  input  logic [PULSE_WIDTH_BITS-1:0] cmd_width,
  output logic                        x_trigger,
  output logic                        y_trigger,
  output logic [PULSE_NUM_BITS-1:0]   x_pulse_num,
  output logic [PULSE_NUM_BITS-1:0]   y_pulse_num,
  output logic [PULSE_WIDTH_BITS-1:0] pulse_width,
  input  logic                        x_busy,
  input  logic                        y_busy,
  output logic                        sched_busy,
`ifdef STEPPER_SCHED_STATS_EN
  output logic [15:0]                 move_count,
`endif
  output logic                        move_done
);

  localparam int unsigned TICK_BITS = $clog2(TRIG_TIMEOUT_TICKS + 1);

  typedef struct packed {
    logic [PULSE_NUM_BITS-1:0]   dx;
    logic [PULSE_NUM_BITS-1:0]   dy;
    logic [PULSE_WIDTH_BITS-1:0] width;
  } cmd_t;

  cmd_t                 push_cmd;
  cmd_t                 head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  sched_state_t         state;
  sched_state_t         state_nxt;
  logic                 done_nxt;
  logic                 x_seen;
  logic                 y_seen;
  logic                 arm_x;
  logic                 arm_y;
  logic                 x_ok;
  logic                 y_ok;
  logic                 timed_out;
  logic [TICK_BITS-1:0] tick_cnt;
  logic [TICK_BITS-1:0] tick_next;

  assign push_cmd = '{dx: cmd_dx, dy: cmd_dy, width: cmd_width};

  move_cmd_fifo #(
    .DEPTH (DEPTH),
    .cmd_t (cmd_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign cmd_ready  = !fifo_full;
  assign sched_busy = (state != IDLE) || !fifo_empty;
  assign arm_x      = (x_pulse_num != '0);
  assign arm_y      = (y_pulse_num != '0);
  assign tick_next  = tick_cnt + TICK_BITS'(clk_en);
  assign timed_out  = (tick_next == TICK_BITS'(TRIG_TIMEOUT_TICKS));
  // An axis counts as seen on the edge its busy is sampled, so TRIG exits on that same edge.
  assign x_ok       = !arm_x || x_seen || x_busy || timed_out;
  assign y_ok       = !arm_y || y_seen || y_busy || timed_out;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    x_trigger = 1'b0;
    y_trigger = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!arm_x && !arm_y) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = TRIG;
        end
      end
      TRIG: begin
        x_trigger = arm_x && !x_seen;
        y_trigger = arm_y && !y_seen;
        if (x_ok && y_ok) state_nxt = RUN;
      end
      RUN: begin
        if ((!arm_x || !x_busy) && (!arm_y || !y_busy)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      move_done   <= 1'b0;
      x_pulse_num <= '0;
      y_pulse_num <= '0;
      pulse_width <= '0;
      x_seen      <= 1'b0;
      y_seen      <= 1'b0;
      tick_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      move_done <= done_nxt;
      if (pop) begin
        x_pulse_num <= head.dx;
        y_pulse_num <= head.dy;
        pulse_width <= head.width;
      end
      if (state == LOAD) begin
        x_seen   <= 1'b0;
        y_seen   <= 1'b0;
        tick_cnt <= '0;
      end else if (state == TRIG) begin
        tick_cnt <= tick_next;
        if (x_busy || timed_out) x_seen <= 1'b1;
        if (y_busy || timed_out) y_seen <= 1'b1;
      end
    end
  end

`ifdef STEPPER_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset)         move_count <= '0;
    else if (move_done) move_count <= move_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_stepper_move_sched.sv
// Directed plus randomized bench for stepper_move_sched with a queue-based move model.
module tb_stepper_move_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_dx;
  logic [7:0] cmd_dy;
  logic [7:0] cmd_width;
  logic       x_trigger;
  logic       y_trigger;
  logic [7:0] x_pulse_num;
  logic [7:0] y_pulse_num;
  logic [7:0] pulse_width;
  logic       x_busy;
  logic       y_busy;
  logic       sched_busy;
  logic       move_done;
`ifdef STEPPER_SCHED_STATS_EN
  logic [15:0] move_count;
`endif

  stepper_move_sched #(
    .PULSE_NUM_BITS   (8),
    .PULSE_WIDTH_BITS (8),
    .DEPTH            (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dx      (cmd_dx),
    .cmd_dy      (cmd_dy),
    .cmd_width   (cmd_width),
    .x_trigger   (x_trigger),
    .y_trigger   (y_trigger),
    .x_pulse_num (x_pulse_num),
    .y_pulse_num (y_pulse_num),
    .pulse_width (pulse_width),
    .x_busy      (x_busy),
    .y_busy      (y_busy),
    .sched_busy  (sched_busy),
`ifdef STEPPER_SCHED_STATS_EN
    .move_count  (move_count),
`endif
    .move_done   (move_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          en_div   = 1;
  int          busy_len = 20;
  int          x_cnt    = 0;
  int          y_cnt    = 0;
  int          x_fall   = 0;
  int          y_fall   = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cnt  = 0;
  int          x_ticks  = 0;
  int          x_trig_last = 0;
  bit          x_stall  = 0;
  bit          y_stall  = 0;
  bit          x_resp   = 1;
  bit          y_resp   = 1;
  bit          x_trig_seen = 0;
  bit          y_trig_seen = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: capture handshake, sample outputs, then advance the axis models.
  task automatic step();
    logic        acc;
    logic [23:0] pend;
    logic [23:0] e;
    logic        xb_prev;
    logic        yb_prev;
    acc  = cmd_valid && cmd_ready && reset;
    pend = {cmd_dx, cmd_dy, cmd_width};
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      exp_q.push_back(pend);
      acc_cnt++;
    end
    clk_en = (en_div <= 1) || (cyc % en_div == 0);
    if (x_trigger) begin
      x_trig_seen = 1;
      x_trig_last = cyc;
      if (clk_en) x_ticks++;
    end
    if (y_trigger) y_trig_seen = 1;
    if (move_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_has_cmd", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("done_cmd", {8'h0, x_pulse_num, y_pulse_num, pulse_width}, {8'h0, e});
      end
    end
    xb_prev = x_busy;
    yb_prev = y_busy;
    if (x_cnt > 0) x_cnt--;
    else if (x_trigger && x_resp) x_cnt = busy_len;
    if (y_cnt > 0) y_cnt--;
    else if (y_trigger && y_resp) y_cnt = busy_len;
    x_busy = x_stall || (x_cnt != 0);
    y_busy = y_stall || (y_cnt != 0);
    if (xb_prev && !x_busy) x_fall = cyc;
    if (yb_prev && !y_busy) y_fall = cyc;
  endtask

  task automatic push(input int dx, input int dy, input int w);
    cmd_dx    = 8'(dx);
    cmd_dy    = 8'(dy);
    cmd_width = 8'(w);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int start;
    start = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == start; i++) step();
    chk("done_within_bound", 32'(done_cnt - start), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_triggers", {30'h0, x_trigger, y_trigger}, 0);
    chk("rst_move_done", 32'(move_done), 0);
    chk("rst_sched_busy", 32'(sched_busy), 0);
    chk("rst_x_pulse_num", 32'(x_pulse_num), 0);
    chk("rst_y_pulse_num", 32'(y_pulse_num), 0);
    chk("rst_pulse_width", 32'(pulse_width), 0);
`ifdef STEPPER_SCHED_STATS_EN
    chk("rst_move_count", 32'(move_count), 0);
`endif
  endtask

  initial begin
    int start;
    int guard;
    int vx;
    int vy;
    logic will_acc;

    reset = 1'b0; clk_en = 1'b1; cmd_valid = 1'b0;
    cmd_dx = '0; cmd_dy = '0; cmd_width = '0;
    x_busy = 1'b0; y_busy = 1'b0;
    repeat (3) step();
    chk_reset_vals();
    reset = 1'b1;
    step();

    // Single move on both axes
    x_trig_seen = 0; y_trig_seen = 0; busy_len = 20;
    start = done_cnt;
    push(-4, 2, 2);
    chk("t1_trig_n1", {30'h0, x_trigger, y_trigger}, 0);
    step();
    chk("t1_trig_n2", {30'h0, x_trigger, y_trigger}, 0);
    step();
    chk("t1_trig_n3", {30'h0, x_trigger, y_trigger}, 3);
    chk("t1_x_pulse_num", 32'(x_pulse_num), 32'hFC);
    chk("t1_y_pulse_num", 32'(y_pulse_num), 32'h02);
    chk("t1_pulse_width", 32'(pulse_width), 2);
    chk("t1_sched_busy", 32'(sched_busy), 1);
    wait_done(60);
    chk("t1_done_timing", 32'(done_cyc), 32'(((x_fall > y_fall) ? x_fall : y_fall) + 1));
    chk("t1_sched_idle", 32'(sched_busy), 0);
    repeat (10) step();
    chk("t1_one_done", 32'(done_cnt - start), 1);

    // Zero move
    x_trig_seen = 0; y_trig_seen = 0;
    push(0, 0, 5);
    step();
    chk("t2_no_done_yet", 32'(move_done), 0);
    step();
    chk("t2_done", 32'(move_done), 1);
    chk("t2_no_trig", {30'h0, x_trig_seen, y_trig_seen}, 0);
    step();
    chk("t2_done_pulse", 32'(move_done), 0);

    // Y-only move, X busy stuck high and ignored
    x_stall = 1; x_trig_seen = 0; y_trig_seen = 0; busy_len = 6;
    step();
    push(0, 3, 1);
    wait_done(40);
    chk("t3_trig_seen", {30'h0, x_trig_seen, y_trig_seen}, 1);
    chk("t3_done_after_y", 32'(done_cyc), 32'(y_fall + 1));
    x_stall = 0;
    repeat (3) step();

    // FIFO full while a stalled move occupies the scheduler
    x_stall = 1; y_stall = 1;
    start = done_cnt;
    push(1, 1, 1);
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      cmd_dx = 8'(i + 2); cmd_dy = 8'(-(i + 2)); cmd_width = 8'(i); cmd_valid = 1'b1;
      step();
      chk("t4_ready_after_push", 32'(cmd_ready), (i < 3) ? 1 : 0);
    end
    cmd_dx = 8'd9; cmd_dy = 8'd7; cmd_width = 8'd4;
    step();
    chk("t4_held_off", 32'(cmd_ready), 0);
    chk("t4_queued", 32'(exp_q.size()), 5);
    x_stall = 0; y_stall = 0; busy_len = 3;
    guard = 0;
    while (cmd_valid && guard < 100) begin
      will_acc = cmd_ready;
      step();
      if (will_acc) cmd_valid = 1'b0;
      guard++;
    end
    chk("t4_fifth_accepted", 32'(cmd_valid), 0);
    guard = 0;
    while ((exp_q.size() != 0 || sched_busy) && guard < 300) begin
      step();
      guard++;
    end
    chk("t4_all_done", 32'(done_cnt - start), 6);

    // Trigger timeout on an unresponsive X axis with clk_en at div 2
    en_div = 2; x_resp = 0; x_ticks = 0;
    push(5, 0, 3);
    wait_done(60);
    chk("t5_timeout_ticks", 32'(x_ticks), 4);
    chk("t5_done_timing", 32'(done_cyc), 32'(x_trig_last + 2));
    chk("t5_trig_low", 32'(x_trigger), 0);
    en_div = 1; x_resp = 1;
    step();

    // Reset mid-move with two commands queued
    x_stall = 1; y_stall = 1;
    cmd_dx = 8'd2; cmd_dy = 8'd2; cmd_width = 8'd1; cmd_valid = 1'b1;
    repeat (3) step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("t6_busy_before_reset", 32'(sched_busy), 1);
    chk("t6_queued", 32'(exp_q.size()), 3);
    reset = 1'b0;
    step();
    exp_q.delete();
    chk_reset_vals();
    reset = 1'b1; x_stall = 0; y_stall = 0;
    start = done_cnt;
    repeat (10) step();
    chk("t6_no_done_after_reset", 32'(done_cnt - start), 0);
    chk("t6_fifo_empty", 32'(sched_busy), 0);

    // Randomized command stream
    start = done_cnt;
    acc_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      vx = $urandom_range(0, 6);
      vy = $urandom_range(0, 6);
      cmd_dx = 8'(vx - 3);
      cmd_dy = 8'(vy - 3);
      cmd_width = 8'($urandom_range(1, 255));
      busy_len = $urandom_range(1, 5);
      cmd_valid = 1'b1;
      guard = 0;
      do begin
        will_acc = cmd_ready;
        step();
        guard++;
      end while (!will_acc && guard < 100);
      cmd_valid = 1'b0;
      chk("rand_accept", 32'(will_acc), 1);
      repeat ($urandom_range(0, 3)) step();
    end
    guard = 0;
    while ((exp_q.size() != 0 || sched_busy) && guard < 500) begin
      step();
      guard++;
    end
    chk("rand_done_count", 32'(done_cnt - start), 32'(acc_cnt));
    chk("rand_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
